// File: rtl/fu_issue_queue_if.sv
// fu_issue_queue_if: RS-issue / FU handshake bundle; slave = queue side, master = RS+FU side
interface fu_issue_queue_if #(
  parameter int ENTRY_WIDTH = 64,
  parameter int ROB_WIDTH   = 4,
  parameter int DEPTH       = 2
);
  logic                         flush;
  logic                         issue_valid;
  logic [ENTRY_WIDTH-1:0]       issue_entry;
  logic [ROB_WIDTH-1:0]         issue_rob_id;
  logic                         busy;
  logic                         fu_valid;
  logic [ENTRY_WIDTH-1:0]       fu_entry;
  logic [ROB_WIDTH-1:0]         fu_rob_id;
  logic                         fu_ready;
  logic [$clog2(DEPTH+1)-1:0]   occupancy;
  logic                         overflow_err;
  modport slave (
    input  flush, issue_valid, issue_entry, issue_rob_id, fu_ready,
    output busy, fu_valid, fu_entry, fu_rob_id, occupancy, overflow_err
  );
  modport master (
    output flush, issue_valid, issue_entry, issue_rob_id, fu_ready,
    input  busy, fu_valid, fu_entry, fu_rob_id, occupancy, overflow_err
  );
endinterface

// File: rtl/fu_issue_queue.sv
// fu_issue_queue: in-order FIFO between RS issue and an FU; ports clk, rst (sync active-low), q (issue in, fu out, busy/occupancy/overflow_err)
module fu_issue_queue #(
  parameter int ENTRY_WIDTH = 64,
  parameter int ROB_WIDTH   = 4,
  parameter int DEPTH       = 2
) (
  input logic clk,
  input logic rst,
  fu_issue_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = ENTRY_WIDTH + ROB_WIDTH;
  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic          full, push, pop, ovf;
  assign full = count == CW'(DEPTH);
  assign push = q.issue_valid && !full && !q.flush;
  assign pop  = count != '0 && q.fu_ready && !q.flush;
  always_ff @(posedge clk)
    if (push) mem[wp] <= {q.issue_rob_id, q.issue_entry};
  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      wp    <= '0;
      rp    <= '0;
      ovf   <= 1'b0;
    end else begin
      if (q.issue_valid && full) ovf <= 1'b1;
      if (q.flush) begin
        count <= '0;
        wp    <= '0;
        rp    <= '0;
      end else begin
        if (push) wp <= wp == PW'(DEPTH - 1) ? '0 : wp + PW'(1);
        if (pop) rp <= rp == PW'(DEPTH - 1) ? '0 : rp + PW'(1);
        count <= push && !pop ? count + CW'(1) : pop && !push ? count - CW'(1) : count;
      end
    end
  end
  assign q.fu_valid     = count != '0;
  assign q.busy         = full;
  assign q.occupancy    = count;
  assign q.overflow_err = ovf;
  assign {q.fu_rob_id, q.fu_entry} = q.fu_valid ? mem[rp] : '0;
endmodule

// File: tb/tb_fu_issue_queue.sv
// tb_fu_issue_queue: scoreboard bench driving a DEPTH=2 and a DEPTH=3 queue with shared stimulus
module tb_fu_issue_queue;
  logic        clk = 0;
  logic        rst, flush, iv, rdy;
  logic [63:0] ie;
  logic [3:0]  ir;
  logic [67:0] q2[$], q3[$];
  logic        ovf2, ovf3;
  int          checks = 0, failures = 0, rx3 = 0, sent = 0;
  always #5 clk = ~clk;
  fu_issue_queue_if #(.DEPTH(2)) b2();
  fu_issue_queue_if #(.DEPTH(3)) b3();
  assign b2.flush = flush;
  assign b2.issue_valid = iv;
  assign b2.issue_entry = ie;
  assign b2.issue_rob_id = ir;
  assign b2.fu_ready = rdy;
  assign b3.flush = flush;
  assign b3.issue_valid = iv;
  assign b3.issue_entry = ie;
  assign b3.issue_rob_id = ir;
  assign b3.fu_ready = rdy;
  fu_issue_queue #(.DEPTH(2)) u2 (.clk(clk), .rst(rst), .q(b2.slave));
  fu_issue_queue #(.DEPTH(3)) u3 (.clk(clk), .rst(rst), .q(b3.slave));
  task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step;
    bit p2, p3;
    chk("occ2", 68'(b2.occupancy), 68'(q2.size()));
    chk("busy2", 68'(b2.busy), 68'(q2.size() == 2));
    chk("vld2", 68'(b2.fu_valid), 68'(q2.size() != 0));
    chk("ovf2", 68'(b2.overflow_err), 68'(ovf2));
    if (q2.size() != 0) chk("head2", {b2.fu_rob_id, b2.fu_entry}, q2[0]);
    else chk("head2_zero", {b2.fu_rob_id, b2.fu_entry}, 68'h0);
    chk("occ3", 68'(b3.occupancy), 68'(q3.size()));
    chk("busy3", 68'(b3.busy), 68'(q3.size() == 3));
    chk("vld3", 68'(b3.fu_valid), 68'(q3.size() != 0));
    chk("ovf3", 68'(b3.overflow_err), 68'(ovf3));
    if (q3.size() != 0) chk("head3", {b3.fu_rob_id, b3.fu_entry}, q3[0]);
    else chk("head3_zero", {b3.fu_rob_id, b3.fu_entry}, 68'h0);
    if (!rst) begin
      q2.delete();
      q3.delete();
      ovf2 = 0;
      ovf3 = 0;
    end else begin
      if (iv && q2.size() == 2) ovf2 = 1;
      if (iv && q3.size() == 3) ovf3 = 1;
      if (flush) begin
        q2.delete();
        q3.delete();
      end else begin
        p2 = iv && q2.size() != 2;
        p3 = iv && q3.size() != 3;
        if (q2.size() != 0 && rdy) void'(q2.pop_front());
        if (q3.size() != 0 && rdy) begin
          void'(q3.pop_front());
          rx3++;
        end
        if (p2) q2.push_back({ir, ie});
        if (p3) q3.push_back({ir, ie});
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 0; flush = 0; iv = 0; ie = '0; ir = '0; rdy = 0; ovf2 = 0; ovf3 = 0;
    @(posedge clk);
    #1;
    step;
    step;
    rst = 1; iv = 1; ir = 3; ie = 64'hA5;
    step;
    iv = 0;
    chk("single_rob", 68'(b2.fu_rob_id), 68'd3);
    chk("single_entry", 68'(b2.fu_entry), 68'hA5);
    step;
    rdy = 1;
    step;
    rdy = 0; iv = 1; ir = 1; ie = 64'h11;
    step;
    ir = 2; ie = 64'h22;
    step;
    chk("full_busy", 68'(b2.busy), 68'd1);
    ir = 4; ie = 64'h44;
    step;
    iv = 0;
    chk("ovf_set", 68'(b2.overflow_err), 68'd1);
    rdy = 1;
    step;
    step;
    step;
    rdy = 0; iv = 1; ir = 5; ie = 64'h55;
    step;
    ir = 6; ie = 64'h66; rdy = 1;
    step;
    iv = 0; rdy = 0;
    chk("simul_head", 68'(b2.fu_rob_id), 68'd6);
    chk("simul_occ", 68'(b2.occupancy), 68'd1);
    step;
    iv = 1; ir = 7; ie = 64'h77;
    step;
    chk("preflush_occ", 68'(b2.occupancy), 68'd2);
    flush = 1; ir = 8; ie = 64'h88; rdy = 1;
    step;
    flush = 0; iv = 0; rdy = 0;
    chk("flush_occ", 68'(b2.occupancy), 68'd0);
    step;
    iv = 1; ir = 9; ie = 64'h99;
    step;
    iv = 0;
    chk("postflush_head", 68'(b2.fu_rob_id), 68'd9);
    step;
    iv = 1; ir = 10; ie = 64'hAA;
    step;
    ir = 11; ie = 64'hBB;
    step;
    iv = 0;
    chk("mid_ovf", 68'(b2.overflow_err), 68'd1);
    rst = 0;
    step;
    rst = 1;
    chk("rst_ovf", 68'(b2.overflow_err), 68'd0);
    chk("rst_occ", 68'(b2.occupancy), 68'd0);
    step;
    rx3 = 0;
    for (int c = 0; c < 200 && (sent < 10 || q3.size() != 0); c++) begin
      iv = sent < 10 && q3.size() < 3;
      ir = 4'(sent);
      ie = {$urandom, $urandom};
      rdy = c % 2 == 0;
      step;
      if (iv) sent++;
    end
    iv = 0; rdy = 0;
    chk("wrap_rx", 68'(rx3), 68'd10);
    chk("wrap_ovf", 68'(b3.overflow_err), 68'd0);
    step;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fu_issue_queue.md
Name: fu_issue_queue

Overview:
- Receive-side endpoint of the reservation-station issue interface, instantiated in front of each functional unit (ALU, LSU, BRU).
- Accepts the issued RS entry (issue_valid + entry), buffers it in a small in-order FIFO, and presents it to the functional unit with a valid/ready handshake.
- Drives the busy back-pressure signal that the reservation station samples before issuing.
- Global flush discards all buffered entries.

Parameters:
- ENTRY_WIDTH, 64, bit width of the packed RS_ENTRY_t payload.
- ROB_WIDTH, 4, width of the ROB index carried alongside the payload.
- DEPTH, 2, number of buffer entries; legal range 2..8, not required to be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous active-low reset.
- flush  input  1  pipeline flush; clears the queue.
- issue_valid  input  1  RS presents an entry this cycle.
- issue_entry  input  ENTRY_WIDTH  packed RS entry.
- issue_rob_id  input  ROB_WIDTH  ROB id of the issued entry.
- busy  output  1  back-pressure to the RS; RS must not assert issue_valid while busy=1.
- fu_valid  output  1  head entry is valid.
- fu_entry  output  ENTRY_WIDTH  head payload.
- fu_rob_id  output  ROB_WIDTH  head ROB id.
- fu_ready  input  1  FU consumes the head when fu_valid && fu_ready.
- occupancy  output  $clog2(DEPTH+1)  number of entries held.
- overflow_err  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0 at a clock edge):
  - count=0, read/write pointers=0, overflow_err=0.
  - Outputs: busy=0, fu_valid=0, occupancy=0.
  - fu_entry and fu_rob_id are driven to 0 while fu_valid=0.
  - Reset has priority over flush and any handshake in the same cycle.
- Storage: circular buffer of DEPTH entries, each holding {entry, rob_id}.
  - Write pointer and read pointer wrap from DEPTH-1 to 0 (explicit compare, not modulo-2^n).
- Push: issue_valid && !busy && !flush.
  - Data is written at the write pointer; the write pointer advances.
  - Latency: an entry pushed at edge N is visible on fu_* after edge N (1-cycle latency). There is no combinational bypass from issue_* to fu_*.
- Pop: fu_valid && fu_ready && !flush; the read pointer advances.
- Count update:
  - Push only: count+1.
  - Pop only: count-1.
  - Push and pop in the same cycle: count unchanged and both pointers advance. This is legal at any count < DEPTH, including count=1 (the head pops while the new entry lands).
- Output decode from registered state only (no input-to-output paths):
  - fu_valid = (count != 0).
  - busy = (count == DEPTH).
  - occupancy = count.
- Full: busy=1 until a pop.
  - issue_valid while busy=1 is a protocol violation: the entry is dropped, the queue is unchanged, and overflow_err is set.
  - overflow_err is sticky; it clears only on reset, not on flush.
- Empty: fu_valid=0, and fu_ready is ignored.
- Flush (rst=1, flush=1):
  - Next state is count=0 with both pointers at 0.
  - Any push or pop in the flush cycle is suppressed.
  - busy=0 and fu_valid=0 from the following cycle.
- Ordering: strictly in issue order; no reordering by ROB age.
- Head stability: fu_entry/fu_rob_id are stable while fu_valid=1 and fu_ready=0.

Test Plan:
- Reset, then single push: rst=0 for 2 cycles → busy=0, fu_valid=0, occupancy=0. Then issue_valid=1, rob_id=3, entry=0xA5, fu_ready=0 → the next cycle shows fu_valid=1, fu_rob_id=3, fu_entry=0xA5, occupancy=1.
- Fill to full: DEPTH=2, fu_ready=0, push rob_id 1 then 2 → occupancy=2, busy=1. A third issue_valid (rob_id 4) is dropped and overflow_err=1. Then fu_ready=1 → rob_id 1 pops, then rob_id 2 pops; rob_id 4 never appears.
- Simultaneous push/pop: occupancy=1 (rob_id 5), issue rob_id 6 with fu_ready=1 → occupancy stays 1, and the head becomes 6 next cycle.
- Pointer wrap: DEPTH=3, stream rob_ids 0..9 with fu_ready toggling 1,0,1,... → the FU receives 0..9 in order, no loss, and overflow_err stays 0.
- Flush: occupancy=2, flush=1 together with issue_valid=1 and fu_ready=1 → next cycle occupancy=0, fu_valid=0, busy=0, and no pop is counted. A push afterward appears at the head correctly.
- Reset mid-operation: occupancy=2 with overflow_err=1, then assert rst=0 → all outputs return to their reset values, including overflow_err=0.
